// File: rtl/uc_seq_pkg.sv
// Shared constants and types for the uc_seq micro-sequencer.
// Opcode classes, FSM state encoding and retired-instruction counter width.
package uc_seq_pkg;

   localparam int ICOUNT_W = 16;

   localparam logic [5:0] OP_HALT      = 6'b111111;
   localparam logic       OP_LI_PREFIX = 1'b1;
   localparam logic [1:0] OP_ALU       = 2'b00;
   localparam logic [1:0] OP_J         = 2'b01;
   localparam logic [1:0] OP_JZ        = 2'b10;
   localparam logic [1:0] OP_JNZ       = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP   = 2'b10,
      ST_HALTED = 2'b11
   } state_t;

   function automatic logic is_halt_op(input logic [5:0] op);
      return op == OP_HALT;
   endfunction

endpackage

// File: rtl/uc_seq_if.sv
// Datapath-facing bundle of uc_seq: opcode/flag/debug controls in, control strobes out.
// master = datapath/debugger side, slave = sequencer side.
interface uc_seq_if;
   import uc_seq_pkg::*;

   logic [5:0]          Opcode;
   logic                zero;
   logic                run;
   logic                step_req;
   logic                resume;
   logic                pc_en;
   logic                s_inc;
   logic                s_inm;
   logic                we;
   logic                wez;
   logic [2:0]          AluOP;
   logic                step_ack;
   logic                halted;
   logic [ICOUNT_W-1:0] icount;

   modport master (
      output Opcode, zero, run, step_req, resume,
      input  pc_en, s_inc, s_inm, we, wez, AluOP, step_ack, halted, icount
   );

   modport slave (
      input  Opcode, zero, run, step_req, resume,
      output pc_en, s_inc, s_inm, we, wez, AluOP, step_ack, halted, icount
   );

endinterface

// File: rtl/uc_dec.sv
// Pure combinational opcode decoder; zero-cycle latency, no flow control.
// Outputs are the raw executing-cycle controls; the caller gates them.
module uc_dec
   import uc_seq_pkg::*;
(
   input  logic [5:0] Opcode,
   input  logic       zero,
   output logic       s_inc,
   output logic       s_inm,
   output logic       we,
   output logic       wez,
   output logic [2:0] AluOP,
   output logic       is_halt
);

   always_comb begin
      s_inc   = 1'b1;
      s_inm   = 1'b0;
      we      = 1'b0;
      wez     = 1'b0;
      AluOP   = 3'b000;
      is_halt = 1'b0;
      if (is_halt_op(Opcode)) begin
         is_halt = 1'b1;
      end else if (Opcode[5] == OP_LI_PREFIX) begin
         s_inm = 1'b1;
         we    = 1'b1;
      end else begin
         unique case (Opcode[1:0])
            OP_ALU: begin
               we    = 1'b1;
               wez   = 1'b1;
               AluOP = Opcode[4:2];
            end
            OP_J:   s_inc = 1'b0;
            // zero comes straight from the datapath flag register
            OP_JZ:  s_inc = ~zero;
            OP_JNZ: s_inc = zero;
         endcase
      end
   end

endmodule

// File: rtl/uc_seq.sv
// Run/step/halt micro-sequencer; controls combinational from state and opcode.
// One instruction per executing cycle; no backpressure, HALTED waits for resume.
module uc_seq
   import uc_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   uc_seq_if.slave     bus
);

   state_t              state;
   state_t              state_nxt;
   logic                exec;
   logic [ICOUNT_W-1:0] icount_q;

   logic       dec_s_inc;
   logic       dec_s_inm;
   logic       dec_we;
   logic       dec_wez;
   logic [2:0] dec_alu_op;
   logic       dec_is_halt;

   uc_dec u_dec (
      .Opcode  (bus.Opcode),
      .zero    (bus.zero),
      .s_inc   (dec_s_inc),
      .s_inm   (dec_s_inm),
      .we      (dec_we),
      .wez     (dec_wez),
      .AluOP   (dec_alu_op),
      .is_halt (dec_is_halt)
   );

   assign exec = (state == ST_RUN) || (state == ST_STEP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            // run wins over a coincident step_req
            if (bus.run)           state_nxt = ST_RUN;
            else if (bus.step_req) state_nxt = ST_STEP;
         end
         ST_RUN: begin
            if (dec_is_halt)       state_nxt = ST_HALTED;
            else if (!bus.run)     state_nxt = ST_IDLE;
         end
         ST_STEP:   state_nxt = dec_is_halt ? ST_HALTED : ST_IDLE;
         ST_HALTED: if (bus.resume) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.pc_en    = 1'b0;
      bus.s_inc    = 1'b1;
      bus.s_inm    = 1'b0;
      bus.we       = 1'b0;
      bus.wez      = 1'b0;
      bus.AluOP    = 3'b000;
      if (exec) begin
         bus.pc_en = 1'b1;
         bus.s_inc = dec_s_inc;
         bus.s_inm = dec_s_inm;
         bus.we    = dec_we;
         bus.wez   = dec_wez;
         bus.AluOP = dec_alu_op;
      end
      bus.step_ack = (state == ST_STEP);
      bus.halted   = (state == ST_HALTED);
   end

   // Every executing cycle retires one instruction, HALT and untaken jumps included.
   always_ff @(posedge clk) begin
      if (reset) begin
         icount_q <= '0;
      end else if (exec) begin
         icount_q <= icount_q + {{(ICOUNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.icount = icount_q;

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_uc_seq;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   uc_seq_if bus();

   uc_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Behavioural model: mode name and retired count, updated at each rising edge.
   string m_st;
   int    m_ic;
   bit    m_valid;

   always @(posedge clk) begin
      if (reset) begin
         m_st    <= "IDLE";
         m_ic    <= 0;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         if (m_st == "IDLE") begin
            if (bus.run)           m_st <= "RUN";
            else if (bus.step_req) m_st <= "STEP";
         end else if (m_st == "RUN") begin
            m_ic <= (m_ic + 1) % 65536;
            if (bus.Opcode == 6'd63) m_st <= "HALTED";
            else if (!bus.run)       m_st <= "IDLE";
         end else if (m_st == "STEP") begin
            m_ic <= (m_ic + 1) % 65536;
            m_st <= (bus.Opcode == 6'd63) ? "HALTED" : "IDLE";
         end else begin
            if (bus.resume) m_st <= "IDLE";
         end
      end
   end

   // {pc_en, s_inc, s_inm, we, wez, AluOP[2:0], step_ack, halted, icount[15:0]}
   function automatic logic [25:0] expect_out(input string st, input int op, input bit z, input int ic);
      bit       pc_en, s_inc, s_inm, we, wez;
      bit [2:0] alu;
      pc_en = 0; s_inc = 1; s_inm = 0; we = 0; wez = 0; alu = 3'd0;
      if (st == "RUN" || st == "STEP") begin
         pc_en = 1;
         if (op == 63) begin
            s_inc = 1;
         end else if (op >= 32) begin
            s_inm = 1; we = 1;
         end else if (op % 4 == 0) begin
            we = 1; wez = 1; alu = 3'((op / 4) % 8);
         end else if (op % 4 == 1) begin
            s_inc = 0;
         end else if (op % 4 == 2) begin
            s_inc = !z;
         end else begin
            s_inc = z;
         end
      end
      return {pc_en, s_inc, s_inm, we, wez, alu, bit'(st == "STEP"), bit'(st == "HALTED"), 16'(ic)};
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         check("cycle_outputs",
               {6'd0, bus.pc_en, bus.s_inc, bus.s_inm, bus.we, bus.wez, bus.AluOP,
                bus.step_ack, bus.halted, bus.icount},
               {6'd0, expect_out(m_st, int'(bus.Opcode), bus.zero, m_ic)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      bus.Opcode = 6'd0; bus.zero = 1'b0; bus.run = 1'b0;
      bus.step_req = 1'b0; bus.resume = 1'b0;
      tick(); tick();
      reset = 1'b0;
      settle();
      check("rst_pc_en",    32'(bus.pc_en), 0);
      check("rst_icount",   32'(bus.icount), 0);
      check("rst_halted",   32'(bus.halted), 0);
      check("rst_step_ack", 32'(bus.step_ack), 0);
      check("rst_s_inc",    32'(bus.s_inc), 1);

      // LI in RUN
      bus.run = 1'b1; bus.Opcode = 6'b100000;
      tick(); settle();
      check("li_pc_en", 32'(bus.pc_en), 1);
      check("li_s_inm", 32'(bus.s_inm), 1);
      check("li_we",    32'(bus.we), 1);
      check("li_wez",   32'(bus.wez), 0);
      tick(); settle();
      check("li_icount", 32'(bus.icount), 1);

      // ADD
      bus.Opcode = 6'b001000; #1;
      check("add_aluop", 32'(bus.AluOP), 32'h2);
      check("add_we_wez_inc_inm", 32'({bus.we, bus.wez, bus.s_inc, bus.s_inm}), 32'hE);
      tick(); settle();

      // JZ taken then not taken
      bus.Opcode = 6'b000010; bus.zero = 1'b1; #1;
      check("jz_taken_s_inc", 32'(bus.s_inc), 0);
      check("jz_taken_we",    32'(bus.we), 0);
      tick(); settle();
      bus.zero = 1'b0; #1;
      check("jz_not_taken_s_inc", 32'(bus.s_inc), 1);
      check("jz_not_taken_we",    32'(bus.we), 0);
      tick(); settle();
      check("jz_icount", 32'(bus.icount), 4);

      // leave RUN, then single step a J
      bus.run = 1'b0;
      tick(); settle();
      check("idle_pc_en",  32'(bus.pc_en), 0);
      check("idle_icount", 32'(bus.icount), 5);
      bus.Opcode = 6'b000001; bus.step_req = 1'b1;
      tick();
      bus.step_req = 1'b0;
      settle();
      check("step_ack", 32'({bus.step_ack, bus.pc_en, bus.s_inc}), 32'h6);
      tick(); settle();
      check("post_step", 32'({bus.step_ack, bus.pc_en}), 0);
      check("step_icount", 32'(bus.icount), 6);

      // HALT, ignored run/step_req, resume
      bus.run = 1'b1; bus.Opcode = 6'b001000;
      tick(); settle();
      bus.Opcode = 6'b111111;
      tick(); settle();
      check("halt_flag",   32'({bus.halted, bus.pc_en}), 32'h2);
      check("halt_icount", 32'(bus.icount), 7);
      bus.step_req = 1'b1;
      tick(); tick(); settle();
      check("halt_ignores", 32'({bus.halted, bus.pc_en, bus.step_ack}), 32'h4);
      check("halt_icount_hold", 32'(bus.icount), 7);
      bus.step_req = 1'b0; bus.resume = 1'b1; bus.Opcode = 6'b100000;
      tick();
      bus.resume = 1'b0;
      settle();
      check("resume_idle", 32'({bus.halted, bus.pc_en}), 0);
      tick(); settle();
      check("resume_run", 32'({bus.halted, bus.pc_en}), 32'h1);

      // randomized traffic, checked by the per-cycle compare
      for (int i = 0; i < 3000; i++) begin
         bus.run      = ($urandom_range(0, 3) != 0);
         bus.step_req = ($urandom_range(0, 3) == 0);
         bus.resume   = ($urandom_range(0, 7) == 0);
         bus.zero     = 1'($urandom_range(0, 1));
         bus.Opcode   = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
         reset        = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0; bus.step_req = 1'b0; bus.resume = 1'b0;

      // counter wrap: 65535 instructions to FFFF, one more to 0000
      reset = 1'b1;
      tick();
      reset = 1'b0; bus.run = 1'b1;
      tick();
      for (int i = 0; i < 65535; i++) begin
         bus.Opcode = 6'($urandom_range(0, 62));
         bus.zero   = 1'($urandom_range(0, 1));
         tick();
      end
      settle();
      check("icount_ffff", 32'(bus.icount), 32'hFFFF);
      bus.run = 1'b0; bus.Opcode = 6'b100000;
      tick(); settle();
      check("icount_wrap", 32'(bus.icount), 0);
      check("wrap_idle_pc_en", 32'(bus.pc_en), 0);

      // reset mid-RUN: interrupted instruction is not counted
      bus.run = 1'b1;
      tick(); tick(); tick(); settle();
      check("pre_reset_pc_en", 32'(bus.pc_en), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      check("midrun_reset_icount", 32'(bus.icount), 0);
      check("midrun_reset_pc_en",  32'(bus.pc_en), 0);
      check("midrun_reset_flags",  32'({bus.halted, bus.step_ack}), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
